// File: rtl/debug_cmd_engine.sv
// ---------------------------------------------------------------------------
// debug_cmd_engine
//
// Command engine for the Nios II on-chip debug slave. Virtual-JTAG strobes
// (already synchronised into clk) drive a DR scan chain. The IR picks one of
// NUM_CH command channels. Each completed scan (update-DR) is queued in a
// small FIFO and handed to the CPU-side debug logic over a valid/ready
// handshake. Commands that do not fit are counted in a saturating counter.
//
// Parameters:
//   DR_WIDTH   scan-chain / command data width (>= 8)
//   IR_WIDTH   instruction width; the IR value selects the channel
//   NUM_CH     number of valid channels (<= 2**IR_WIDTH)
//   FIFO_DEPTH command FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, reset_n         clock (rising edge) and asynchronous active-low reset
//   vs_cdr/sdr/udr/uir   capture-DR, shift-DR, update-DR and update-IR strobes
//   ir_in                instruction value, loaded on vs_uir
//   tdi                  serial data in, sampled on vs_sdr
//   cap_data             capture words; channel k at [k*DR_WIDTH +: DR_WIDTH]
//   tdo                  serial data out (LSB of the scan chain)
//   ir_out               status: bit0 FIFO full, bit1 overflow sticky
//   jdo, cmd_ch          data and channel of the command at the FIFO head
//   cmd_valid, cmd_ready handshake for the head command
//   drop_cnt             saturating count of dropped commands
//
// Optional feature macro: DEBUG_CMD_PARITY_EN
//   When defined, the MSB of the scan word is an odd-parity bit over the
//   remaining bits; update-DR with bad parity drops the word and counts it.
// ---------------------------------------------------------------------------
module debug_cmd_engine #(
   parameter int DR_WIDTH   = 38,
   parameter int IR_WIDTH   = 2,
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         vs_cdr,
   input  logic                         vs_sdr,
   input  logic                         vs_udr,
   input  logic                         vs_uir,
   input  logic [IR_WIDTH-1:0]          ir_in,
   input  logic                         tdi,
   input  logic [NUM_CH*DR_WIDTH-1:0]   cap_data,
   output logic                         tdo,
   output logic [IR_WIDTH-1:0]          ir_out,
   output logic [DR_WIDTH-1:0]          jdo,
   output logic [IR_WIDTH-1:0]          cmd_ch,
   output logic                         cmd_valid,
   input  logic                         cmd_ready,
   output logic [7:0]                   drop_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = IR_WIDTH + DR_WIDTH;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   logic [DR_WIDTH-1:0] r_sr;
   logic [IR_WIDTH-1:0] r_irReg;
   logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_rdPtr;
   logic [PTR_W-1:0]    r_wrPtr;
   logic [CNT_W-1:0]    r_count;
   logic                r_ovf;
   logic [7:0]          r_dropCnt;

   logic                w_cdr;
   logic                w_sdr;
   logic                w_udr;
   logic                w_chValid;
   logic                w_parityOk;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_push;
   logic                w_ovfDrop;
   logic                w_parDrop;
   logic [DR_WIDTH-1:0] w_capWord;
   logic [ENT_W-1:0]    w_head;

   // Strobe priority: capture beats shift beats update.
   assign w_cdr = vs_cdr;
   assign w_sdr = vs_sdr & ~vs_cdr;
   assign w_udr = vs_udr & ~vs_cdr & ~vs_sdr;

   assign w_chValid = (int'(r_irReg) < NUM_CH);
   assign w_full    = (r_count == CNT_FULL);
   assign w_empty   = (r_count == '0);
   assign w_pop     = ~w_empty & cmd_ready;

`ifdef DEBUG_CMD_PARITY_EN
   // Odd parity over the whole word, parity bit included, means a good word.
   assign w_parityOk = ^r_sr;
`else
   assign w_parityOk = 1'b1;
`endif

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push    = w_udr & w_chValid & w_parityOk & (~w_full | w_pop);
   assign w_ovfDrop = w_udr & w_chValid & w_parityOk & w_full & ~w_pop;
   assign w_parDrop = w_udr & w_chValid & ~w_parityOk;

   // Capture word select; channels at or above NUM_CH capture zero.
   always_comb begin
      w_capWord = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (int'(r_irReg) == k) begin
            w_capWord = cap_data[k*DR_WIDTH +: DR_WIDTH];
         end
      end
   end

   // Scan chain: parallel capture or shift right with tdi entering the MSB.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sr <= '0;
      end else if (w_cdr) begin
         r_sr <= w_capWord;
      end else if (w_sdr) begin
         r_sr <= {tdi, r_sr[DR_WIDTH-1:1]};
      end
   end

   // Instruction register and overflow sticky; a new overflow beats the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irReg <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (vs_uir) begin
            r_irReg <= ir_in;
         end
         if (w_ovfDrop) begin
            r_ovf <= 1'b1;
         end else if (vs_uir) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at a power of 2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // FIFO storage holds {channel, data}; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= {r_irReg, r_sr};
      end
   end

   // Saturating drop counter for overflow and parity drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dropCnt <= '0;
      end else if ((w_ovfDrop || w_parDrop) && (r_dropCnt != 8'hFF)) begin
         r_dropCnt <= r_dropCnt + 8'd1;
      end
   end

   // Head outputs are forced to zero while empty so reset values are clean.
   assign w_head    = r_mem[r_rdPtr];
   assign jdo       = w_empty ? '0 : w_head[DR_WIDTH-1:0];
   assign cmd_ch    = w_empty ? '0 : w_head[ENT_W-1:DR_WIDTH];
   assign cmd_valid = ~w_empty;
   assign tdo       = r_sr[0];
   assign drop_cnt  = r_dropCnt;

   always_comb begin
      ir_out    = '0;
      ir_out[0] = w_full;
      ir_out[1] = r_ovf;
   end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_debug_cmd_engine
//
// Self-checking bench for debug_cmd_engine built with NUM_CH = 3 so that
// IR value 3 is an invalid channel. A per-cycle vector table covers strobe
// priority, push/pop/overflow and status bits; hand-written sequences cover
// scan capture/shift, the command path, back-pressure, full-with-pop,
// invalid channels, drop-count saturation and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_debug_cmd_engine;

   localparam int DW = 38;
   localparam int IW = 2;
   localparam int NC = 3;
   localparam int FD = 4;

   logic            clk       = 1'b0;
   logic            reset_n   = 1'b0;
   logic            vs_cdr    = 1'b0;
   logic            vs_sdr    = 1'b0;
   logic            vs_udr    = 1'b0;
   logic            vs_uir    = 1'b0;
   logic [IW-1:0]   ir_in     = '0;
   logic            tdi       = 1'b0;
   logic [NC*DW-1:0] cap_data;
   logic            tdo;
   logic [IW-1:0]   ir_out;
   logic [DW-1:0]   jdo;
   logic [IW-1:0]   cmd_ch;
   logic            cmd_valid;
   logic            cmd_ready = 1'b0;
   logic [7:0]      drop_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          uir;
      logic [IW-1:0] irIn;
      logic          cdr;
      logic          sdr;
      logic          udr;
      logic          tdiBit;
      logic          rdy;
      logic          expValid;
      logic [IW-1:0] expIr;
      logic [7:0]    expDrop;
      logic          expTdo;
   } vec_t;

   vec_t          vecs [20];
   logic [DW-1:0] words [6];

   debug_cmd_engine #(
      .DR_WIDTH   (DW),
      .IR_WIDTH   (IW),
      .NUM_CH     (NC),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .vs_cdr    (vs_cdr),
      .vs_sdr    (vs_sdr),
      .vs_udr    (vs_udr),
      .vs_uir    (vs_uir),
      .ir_in     (ir_in),
      .tdi       (tdi),
      .cap_data  (cap_data),
      .tdo       (tdo),
      .ir_out    (ir_out),
      .jdo       (jdo),
      .cmd_ch    (cmd_ch),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .drop_cnt  (drop_cnt)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs; strobes are single-cycle, ready is held.
   task automatic applyStimulus(input logic uir, input logic [IW-1:0] irIn, input logic cdr,
                                input logic sdr, input logic udr, input logic t, input logic rdy);
      vs_uir    = uir;
      ir_in     = irIn;
      vs_cdr    = cdr;
      vs_sdr    = sdr;
      vs_udr    = udr;
      tdi       = t;
      cmd_ready = rdy;
      tick();
      vs_uir = 1'b0;
      vs_cdr = 1'b0;
      vs_sdr = 1'b0;
      vs_udr = 1'b0;
      tdi    = 1'b0;
   endtask

   task automatic setIr(input logic [IW-1:0] v);
      applyStimulus(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0, cmd_ready);
   endtask

   task automatic shiftWord(input logic [DW-1:0] w);
      for (int i = 0; i < DW; i++) begin
         applyStimulus(1'b0, ir_in, 1'b0, 1'b1, 1'b0, w[i], cmd_ready);
      end
   endtask

   task automatic pushWord(input logic [DW-1:0] w);
      shiftWord(w);
      applyStimulus(1'b0, ir_in, 1'b0, 1'b0, 1'b1, 1'b0, cmd_ready);
   endtask

   function automatic vec_t mk(input int uir, input int irIn, input int cdr, input int sdr,
                               input int udr, input int t, input int rdy, input int v,
                               input int io, input int d, input int to);
      vec_t r;
      r.uir      = 1'(uir);
      r.irIn     = IW'(irIn);
      r.cdr      = 1'(cdr);
      r.sdr      = 1'(sdr);
      r.udr      = 1'(udr);
      r.tdiBit   = 1'(t);
      r.rdy      = 1'(rdy);
      r.expValid = 1'(v);
      r.expIr    = IW'(io);
      r.expDrop  = 8'(d);
      r.expTdo   = 1'(to);
      return r;
   endfunction

   initial begin
      logic [DW-1:0] capWord;
      logic [DW-1:0] shiftedOut;

      cap_data = {38'h0F0F0F0F0F, 38'h2A5A5A5A5A, 38'h1111111111};
      words[0] = 38'h2000000001;
      words[1] = 38'h1234567893;
      words[2] = 38'h0ABCDEF005;
      words[3] = 38'h3FFFFFFFF7;
      words[4] = 38'h0000000009;
      words[5] = 38'h155555555B;

      //             uir ir cdr sdr udr tdi rdy  valid io drop tdo
      vecs[0]  = mk(1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
      vecs[1]  = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1);
      vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 1);
      vecs[4]  = mk(0, 0, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      vecs[5]  = mk(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0);
      vecs[6]  = mk(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0);
      vecs[7]  = mk(0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0);
      vecs[8]  = mk(0, 0, 0, 0, 1, 0, 1,  1, 1, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0,  1, 3, 1, 0);
      vecs[10] = mk(1, 3, 0, 0, 0, 0, 0,  1, 1, 1, 0);
      vecs[11] = mk(0, 3, 0, 0, 1, 0, 0,  1, 1, 1, 0);
      vecs[12] = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0);
      vecs[13] = mk(1, 0, 0, 0, 1, 0, 0,  1, 3, 2, 0);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 1,  1, 2, 2, 0);
      vecs[15] = mk(0, 0, 0, 0, 0, 0, 1,  1, 2, 2, 0);
      vecs[16] = mk(0, 0, 0, 0, 0, 0, 1,  1, 2, 2, 0);
      vecs[17] = mk(0, 0, 0, 0, 0, 0, 1,  0, 2, 2, 0);
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 1,  0, 2, 2, 0);
      vecs[19] = mk(0, 0, 1, 0, 0, 0, 0,  0, 2, 2, 1);

      // Reset values.
      tick();
      tick();
      checkOutput("rst_tdo",    64'(tdo),       64'h0);
      checkOutput("rst_ir_out", 64'(ir_out),    64'h0);
      checkOutput("rst_jdo",    64'(jdo),       64'h0);
      checkOutput("rst_cmd_ch", 64'(cmd_ch),    64'h0);
      checkOutput("rst_valid",  64'(cmd_valid), 64'h0);
      checkOutput("rst_drop",   64'(drop_cnt),  64'h0);
      reset_n = 1'b1;
      tick();

      // Per-cycle vector table.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].uir, vecs[i].irIn, vecs[i].cdr, vecs[i].sdr,
                       vecs[i].udr, vecs[i].tdiBit, vecs[i].rdy);
         checkOutput($sformatf("vec%0d_valid", i), 64'(cmd_valid), 64'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d_ir_out", i), 64'(ir_out),   64'(vecs[i].expIr));
         checkOutput($sformatf("vec%0d_drop", i),  64'(drop_cnt),  64'(vecs[i].expDrop));
         checkOutput($sformatf("vec%0d_tdo", i),   64'(tdo),       64'(vecs[i].expTdo));
      end

      // Drop counter saturates at 255 with the FIFO held full.
      for (int i = 0; i < FD + 256; i++) begin
         applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("sat_drop",   64'(drop_cnt), 64'd255);
      checkOutput("sat_ir_out", 64'(ir_out),   64'h3);

      // Asynchronous reset with a full FIFO clears state before any edge.
      reset_n = 1'b0;
      #2;
      checkOutput("arst_valid",  64'(cmd_valid), 64'h0);
      checkOutput("arst_drop",   64'(drop_cnt),  64'h0);
      checkOutput("arst_ir_out", 64'(ir_out),    64'h0);
      checkOutput("arst_jdo",    64'(jdo),       64'h0);
      tick();
      reset_n = 1'b1;
      tick();

      // Capture ch1 and shift it out LSB first with tdi = 0.
      setIr(2'd1);
      applyStimulus(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      capWord = 38'h2A5A5A5A5A;
      shiftedOut = '0;
      for (int i = 0; i < DW; i++) begin
         shiftedOut[i] = tdo;
         applyStimulus(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("shift_seq",  64'(shiftedOut), 64'(capWord));
      checkOutput("shift_zero", 64'(tdo),        64'h0);

      // Command path on ch2.
      setIr(2'd2);
      applyStimulus(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("cap_ch2_tdo", 64'(tdo), 64'h1);
      pushWord(38'h00DEADBEEF);
      checkOutput("cmd_valid", 64'(cmd_valid), 64'h1);
      checkOutput("cmd_jdo",   64'(jdo),       64'h00DEADBEEF);
      checkOutput("cmd_ch",    64'(cmd_ch),    64'h2);
      applyStimulus(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("cmd_popped", 64'(cmd_valid), 64'h0);
      cmd_ready = 1'b0;

      // Back-pressure: five pushes into four entries.
      for (int k = 0; k < 5; k++) begin
         pushWord(words[k]);
         if (k == 3) checkOutput("bp_full", 64'(ir_out), 64'h1);
      end
      checkOutput("bp_ir_out", 64'(ir_out),   64'h3);
      checkOutput("bp_drop",   64'(drop_cnt), 64'h1);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("bp_drain%0d_valid", k), 64'(cmd_valid), 64'h1);
         checkOutput($sformatf("bp_drain%0d_jdo", k),   64'(jdo),       64'(words[k]));
         cmd_ready = 1'b1;
         tick();
         if (k == 0) checkOutput("bp_notfull", 64'(ir_out), 64'h2);
      end
      cmd_ready = 1'b0;
      checkOutput("bp_empty", 64'(cmd_valid), 64'h0);

      // Full FIFO with a push and pop in the same cycle.
      setIr(2'd2);
      checkOutput("ovf_clear", 64'(ir_out), 64'h0);
      for (int k = 0; k < 4; k++) pushWord(words[k]);
      shiftWord(words[5]);
      applyStimulus(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("fp_ir_out", 64'(ir_out),   64'h1);
      checkOutput("fp_drop",   64'(drop_cnt), 64'h1);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("fp_drain%0d_jdo", k),
                     64'(jdo), 64'(words[(k == 3) ? 5 : k + 1]));
         cmd_ready = 1'b1;
         tick();
      end
      cmd_ready = 1'b0;
      checkOutput("fp_empty", 64'(cmd_valid), 64'h0);

      // Invalid channel: no push, no count, no overflow even when full.
      for (int k = 0; k < 4; k++) pushWord(words[k]);
      setIr(2'd3);
      applyStimulus(1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("inv_ir_out", 64'(ir_out),   64'h1);
      checkOutput("inv_drop",   64'(drop_cnt), 64'h1);
      checkOutput("inv_pre_tdo", 64'(tdo),     64'h1);
      applyStimulus(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      shiftedOut = '1;
      for (int i = 0; i < DW; i++) begin
         shiftedOut[i] = tdo;
         applyStimulus(1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("inv_cap_zero", 64'(shiftedOut), 64'h0);
      checkOutput("inv_ch",       64'(cmd_ch),     64'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/debug_cmd_engine.md
# debug_cmd_engine

Parametrised single-clock command engine for the Nios II on-chip debug slave. It takes virtual-JTAG capture, shift and update strobes (already synchronised into `clk`), runs a DR scan chain of configurable width, and decodes the IR into up to `NUM_CH` command channels. Completed scans are buffered in a FIFO and handed to the CPU-side debug logic through a valid/ready handshake. It replaces the fixed 2-bit-IR, 38-bit-DR sysclk decoder and adds buffering, back-pressure and drop accounting.

## Interface
- `DR_WIDTH`, 38, scan-chain / command data width (≥ 8)
- `IR_WIDTH`, 2, instruction width; channel = IR value
- `NUM_CH`, 4, number of valid channels (≤ 2^IR_WIDTH)
- `FIFO_DEPTH`, 4, command FIFO entries (power of 2, ≥ 2)
- `clk`  in  1  system clock; all logic is on its rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `vs_cdr`  in  1  capture-DR strobe, one-cycle pulse
- `vs_sdr`  in  1  shift-DR strobe, one pulse per shifted bit
- `vs_udr`  in  1  update-DR strobe, one-cycle pulse
- `vs_uir`  in  1  update-IR strobe, one-cycle pulse
- `ir_in`  in  IR_WIDTH  instruction value
- `tdi`  in  1  serial data in, sampled on `vs_sdr`
- `cap_data`  in  NUM_CH*DR_WIDTH  capture words; channel k occupies bits [k*DR_WIDTH +: DR_WIDTH]
- `tdo`  out  1  serial data out, equal to `sr[0]`
- `ir_out`  out  IR_WIDTH  status: bit0 = FIFO full, bit1 = overflow sticky, upper bits 0
- `jdo`  out  DR_WIDTH  command data at the FIFO head
- `cmd_ch`  out  IR_WIDTH  channel of the head command
- `cmd_valid`  out  1  FIFO non-empty
- `cmd_ready`  in  1  consumer accepts the head when high together with `cmd_valid`
- `drop_cnt`  out  8  saturating count of dropped commands

## Operation
- Registers: `sr[DR_WIDTH-1:0]`, `ir_reg`, the FIFO (storage, rd/wr pointers, count), `ovf` sticky, and `drop_cnt`.
- Data strobes are nominally exclusive. If several are asserted together, priority is `vs_cdr` > `vs_sdr` > `vs_udr`, and the lower-priority strobes are ignored that cycle. `vs_uir` is handled independently.
- `vs_uir`: `ir_reg <= ir_in` and `ovf` clears. If `vs_udr` is also accepted in the same cycle, an overflow from that push sets `ovf` (set wins).
- `vs_cdr`: `sr <= cap_data` slice for `ir_reg`. If `ir_reg ≥ NUM_CH`, `sr <= 0`.
- `vs_sdr`: `sr <= {tdi, sr[DR_WIDTH-1:1]}`, so the LSB shifts out first.
- `vs_udr`:
  - If `ir_reg ≥ NUM_CH`: the command is discarded silently, with no count and no `ovf`.
  - Else if the FIFO is not full, or a pop occurs this cycle: push `{ir_reg, sr}`.
  - Else: drop the command, set `ovf`, and increment `drop_cnt` (saturating at 255).
- Pop happens when `cmd_valid & cmd_ready`. Pointers wrap modulo `FIFO_DEPTH`. A simultaneous push and pop when full, or when empty-then-pushed, keeps the count consistent.
- `jdo` and `cmd_ch` are held stable while `cmd_valid` is high and not popped. Their value is don't-care when `cmd_valid` is low, but they are driven 0 after reset.
- Reset mid-scan or mid-handshake: everything returns immediately to reset values, and FIFO contents are lost.

## Timing
- Reset values: `sr`, `tdo`, `jdo`, `cmd_ch`, `cmd_valid`, `ir_out`, `drop_cnt`, `ovf` and `ir_reg` are all 0.
- `tdo` updates in the cycle after `vs_cdr` or `vs_sdr`.
- Latency from a `vs_udr` pulse in cycle N (FIFO empty) to `cmd_valid` = 1 with data in cycle N+1.
- After a pop in cycle N, the next head is presented in cycle N+1. `cmd_valid` falls in N+1 if the FIFO becomes empty.
- Full-to-not-full: `ir_out[0]` deasserts the cycle after the pop.
- Throughput: one command per cycle in and out.

## Configuration
- `DEBUG_CMD_PARITY_EN` defined:
  - `sr[DR_WIDTH-1]` is an odd-parity bit over `sr[DR_WIDTH-2:0]`.
  - On `vs_udr`, a word with bad parity is not pushed and increments `drop_cnt`, but does not set `ovf`.
- Undefined: no check is made, and all `DR_WIDTH` bits are payload.

## Test plan
- Capture/shift: reset, `vs_uir` with `ir_in`=1, `cap_data` ch1 = 38'h2A5A5A5A5A, `vs_cdr`, then 38 `vs_sdr` with `tdi`=0 -> `tdo` sequence equals the capture word, LSB first; `sr` ends at 0.
- Command path: shift in 38'h00DEADBEEF on ch2, then `vs_udr` -> next cycle `cmd_valid`=1, `jdo`=38'h00DEADBEEF, `cmd_ch`=2; with `cmd_ready`=1 -> `cmd_valid`=0 the following cycle.
- Back-pressure: `cmd_ready`=0, five `vs_udr` with `FIFO_DEPTH`=4 -> `ir_out`=2'b11, `drop_cnt`=1; draining yields the first four words in order.
- Full + simultaneous pop: FIFO full, `vs_udr` in the same cycle as a pop -> push accepted, `drop_cnt` unchanged, count stays 4.
- Invalid channel: `NUM_CH`=3, `ir_in`=3, `vs_cdr` -> `sr`=0; `vs_udr` -> no push, `drop_cnt`=0, `ovf`=0.
- Parity (macro on): `vs_udr` with even-parity word -> no push, `drop_cnt`+1; odd-parity word -> pushed.
